mips_fetch_stage: RTL and testbench
===================================

// Module: mips_fetch_stage
// PURPOSE
//  Instruction-fetch stage sitting directly upstream of the MIPS core's decode stage.
//  - Holds the PC and reads a 32-bit word from the byte-addressed instruction memory array.
//  - Registers the word into the IF/ID pipeline register; honours decode stalls and branch redirects.
//  - Detects program end (a run of consecutive NOP words) and freezes fetch.
// PARAMETERS
//  IMEM_BYTES  256        size of instruction_mem in bytes
//  RESET_PC    32'h0      PC value loaded on reset (word aligned)
//  HALT_NOPS   4          consecutive fetched NOP words that assert halted_o (>=1)
// PORTS
//  clk                 in   1                  rising-edge clock
//  reset               in   1                  asynchronous, active-high reset
//  instruction_mem     in   [7:0] x IMEM_BYTES instruction bytes; word at a = {m[a+3],m[a+2],m[a+1],m[a]}
//  stall_i             in   1                  decode not ready: hold PC and IF/ID
//  redirect_i          in   1                  taken branch/jump: load redirect_pc_i, squash IF/ID
//  redirect_pc_i       in   32                 redirect target byte address
//  pc_o                out  32                 current fetch PC
//  if_id_instr_o       out  32                 registered instruction to decode
//  if_id_pc4_o         out  32                 registered PC+4 of that instruction
//  if_id_valid_o       out  1                  IF/ID holds a real fetched instruction
//  halted_o            out  1                  fetch frozen after HALT_NOPS NOPs (sticky)
//  fault_o             out  1                  sticky: out-of-range fetch or misaligned redirect
// BEHAVIOUR
//  Reset (async, any time, including mid-stall or mid-redirect):
//  - pc_o=RESET_PC; if_id_instr_o=0; if_id_pc4_o=0; if_id_valid_o=0.
//  - halted_o=0; fault_o=0; NOP counter=0.
//  Per rising edge, priority order: redirect > halted > stall > normal.
//  - Redirect: pc<=redirect_pc_i & ~3; IF/ID<=bubble (instr=0, valid=0); NOP counter<=0.
//    Acts even when stall_i=1 or halted_o=1; clears halted_o.
//    redirect_pc_i[1:0]!=0 additionally sets fault_o.
//  - Halted: PC and NOP counter hold; IF/ID<=bubble.
//  - Stall: PC, IF/ID and NOP counter all hold their values.
//  - Normal: IF/ID<={word@pc, pc+4, valid=1}; pc<=pc+4 (32-bit wrap, no saturation).
//  Fetch latency: the word at pc_o appears on if_id_instr_o one cycle later.
//  Out of range: if pc+3 >= IMEM_BYTES, the fetched word is forced to 0 (NOP), valid=1, and fault_o sets.
//  NOP counter:
//  - A normal fetch of 32'h0 increments it, saturating at HALT_NOPS; any nonzero word clears it.
//  - When it reaches HALT_NOPS, halted_o=1 on the same edge.
//  - The HALT_NOPS-th NOP is still issued to IF/ID; the PC does not advance past it.
//  fault_o is diagnostic only; it does not stop fetch and is cleared only by reset.
//  pc_o and all IF/ID outputs are registers. Memory read is combinational from pc.
// STRUCTURE
//  mips_pkg (shared):
//  - localparam logic [31:0] MIPS_NOP = 32'h0; localparam WORD_BYTES = 4.
//  - typedef struct packed {logic [31:0] instr; logic [31:0] pc4; logic valid;} if_id_t.
//  Sub-module mips_imem_word_read (combinational):
//  - Inputs: byte array, pc. Outputs: assembled little-endian word, out_of_range flag.
//  - Top level holds the PC register, the IF/ID register, the NOP counter and the sticky flags.
// TESTING
//  1. Reset; mem[3:0]={20,0a,00,0a} -> after 1 edge: if_id_instr_o=200a000a, if_id_pc4_o=4, pc_o=8 after 2 edges.
//  2. Stall_i=1 for 3 cycles at pc=8 -> pc_o=8 and IF/ID unchanged throughout; resumes at pc=8 with pc_o=C next.
//  3. Redirect_i=1, redirect_pc_i=0x14, together with stall_i=1 -> next edge: pc_o=0x14, if_id_valid_o=0, fault_o=0.
//  4. Four consecutive zero words at 0x28..0x34 -> halted_o=1 on the 4th fetch edge; pc_o stays 0x34 and valid=0 afterwards.
//     A nonzero word among 3 NOPs resets the count (no halt).
//  5. Redirect to 0x1F -> pc_o=0x1C, fault_o=1; fetch at pc=0xFC with IMEM_BYTES=256 is in range.
//     Fetch at pc=0x100 yields instr=0 and fault_o=1.
//  6. Assert reset mid-stall and mid-halt -> all outputs return to reset values immediately, asynchronously, before the next edge.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mips_pkg
// Description : Shared constants and the IF/ID pipeline register layout.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam logic [31:0] MIPS_NOP   = 32'h0;
    localparam int          WORD_BYTES = 4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

endpackage
`default_nettype wire

// File: rtl/mips_imem_word_read.sv
`default_nettype none
// ============================================================================
// Module      : mips_imem_word_read
// Description : Combinational little-endian word read from the byte array,
//               forcing a NOP and flagging any word not fully inside memory.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_imem_word_read
    import mips_pkg::*;
#(
    parameter int IMEM_BYTES = 256
) (
    input  logic [7:0]  instruction_mem [IMEM_BYTES],
    input  logic [31:0] pc,
    output logic [31:0] word_o,
    output logic        out_of_range_o
);

    localparam int AW = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;

    logic [32:0]   w_last_byte;
    logic [AW-1:0] w_base;

    // 33-bit sum so a PC near the top of the address space cannot wrap into range
    assign w_last_byte    = {1'b0, pc} + 33'(WORD_BYTES - 1);
    assign out_of_range_o = (w_last_byte >= 33'(IMEM_BYTES));
    assign w_base         = pc[AW-1:0];

    always_comb begin
        word_o = MIPS_NOP;
        if (!out_of_range_o) begin
            for (int k = 0; k < WORD_BYTES; k++) begin
                word_o[8*k +: 8] = instruction_mem[w_base + AW'(k)];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mips_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : mips_fetch_stage
// Description : Instruction fetch stage: PC, IF/ID register, stall/redirect
//               handling and NOP-run program-end detection.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_fetch_stage
    import mips_pkg::*;
#(
    parameter int          IMEM_BYTES = 256,
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int          HALT_NOPS  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  instruction_mem [IMEM_BYTES],
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] pc_o,
    output logic [31:0] if_id_instr_o,
    output logic [31:0] if_id_pc4_o,
    output logic        if_id_valid_o,
    output logic        halted_o,
    output logic        fault_o
);

    localparam int             CW        = $clog2(HALT_NOPS + 1);
    localparam logic [CW-1:0]  C_HALT_CNT = CW'(HALT_NOPS);
    localparam if_id_t         C_BUBBLE  = '{instr: MIPS_NOP, pc4: 32'h0, valid: 1'b0};

    logic [31:0]   pc_q, pc_d;
    if_id_t        if_id_q, if_id_d;
    logic [CW-1:0] nop_cnt_q, nop_cnt_d;
    logic          halted_q, halted_d;
    logic          fault_q, fault_d;

    logic [31:0]   w_word;
    logic          w_oor;
    logic [31:0]   w_pc4;
    logic [CW-1:0] w_cnt_inc;

    mips_imem_word_read #(
        .IMEM_BYTES (IMEM_BYTES)
    ) u_imem_read (
        .instruction_mem (instruction_mem),
        .pc              (pc_q),
        .word_o          (w_word),
        .out_of_range_o  (w_oor)
    );

    assign w_pc4     = pc_q + 32'd4;
    assign w_cnt_inc = (nop_cnt_q == C_HALT_CNT) ? nop_cnt_q : nop_cnt_q + 1'b1;

    always_comb begin
        pc_d      = pc_q;
        if_id_d   = if_id_q;
        nop_cnt_d = nop_cnt_q;
        halted_d  = halted_q;
        fault_d   = fault_q;

        if (redirect_i) begin
            pc_d      = redirect_pc_i & ~32'h3;
            if_id_d   = C_BUBBLE;
            nop_cnt_d = '0;
            halted_d  = 1'b0;
            if (redirect_pc_i[1:0] != 2'b00) fault_d = 1'b1;
        end else if (halted_q) begin
            if_id_d = C_BUBBLE;
        end else if (!stall_i) begin
            if_id_d = '{instr: w_word, pc4: w_pc4, valid: 1'b1};
            if (w_oor) fault_d = 1'b1;
            if (w_word == MIPS_NOP) begin
                nop_cnt_d = w_cnt_inc;
                // The final NOP of the run is issued, but the PC parks on it
                if (w_cnt_inc == C_HALT_CNT) halted_d = 1'b1;
                else                         pc_d     = w_pc4;
            end else begin
                nop_cnt_d = '0;
                pc_d      = w_pc4;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            if_id_q   <= C_BUBBLE;
            nop_cnt_q <= '0;
            halted_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            if_id_q   <= if_id_d;
            nop_cnt_q <= nop_cnt_d;
            halted_q  <= halted_d;
            fault_q   <= fault_d;
        end
    end

    assign pc_o          = pc_q;
    assign if_id_instr_o = if_id_q.instr;
    assign if_id_pc4_o   = if_id_q.pc4;
    assign if_id_valid_o = if_id_q.valid;
    assign halted_o      = halted_q;
    assign fault_o       = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_fetch_stage
// Description : Self-checking bench for mips_fetch_stage (directed + random).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_fetch_stage;

    localparam int MEMB = 256;
    localparam int HN   = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  mem [MEMB];
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] rpc = 32'h0;
    logic [31:0] pc_o, instr_o, pc4_o;
    logic        valid_o, halted_o, fault_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_halt, m_fault;
    int          m_cnt;

    mips_fetch_stage #(
        .IMEM_BYTES (MEMB),
        .RESET_PC   (32'h0),
        .HALT_NOPS  (HN)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .instruction_mem (mem),
        .stall_i         (stall),
        .redirect_i      (redirect),
        .redirect_pc_i   (rpc),
        .pc_o            (pc_o),
        .if_id_instr_o   (instr_o),
        .if_id_pc4_o     (pc4_o),
        .if_id_valid_o   (valid_o),
        .halted_o        (halted_o),
        .fault_o         (fault_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] word_at(input int a);
        return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    endfunction

    task automatic set_word(input int a, input logic [31:0] w);
        {mem[a+3], mem[a+2], mem[a+1], mem[a]} = w;
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
        m_valid = 1'b0; m_halt = 1'b0; m_fault = 1'b0; m_cnt = 0;
    endtask

    // One clock of the fetch rules, evaluated from the current inputs
    task automatic model_step();
        logic [31:0] w;
        bit          oor;
        if (redirect) begin
            if (rpc % 4 != 0) m_fault = 1'b1;
            m_pc = rpc - (rpc % 4);
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            m_cnt = 0; m_halt = 1'b0;
        end else if (m_halt) begin
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (!stall) begin
            oor = (longint'(m_pc) + 3 >= longint'(MEMB));
            w = oor ? 32'h0 : word_at(int'(m_pc));
            if (oor) m_fault = 1'b1;
            m_instr = w; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
            if (w == 32'h0) begin
                m_cnt = (m_cnt + 1 > HN) ? HN : m_cnt + 1;
                if (m_cnt == HN) m_halt = 1'b1;
                else             m_pc = m_pc + 32'd4;
            end else begin
                m_cnt = 0;
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; rpc = 32'h0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic init_dir_mem();
        for (int a = 0; a < MEMB; a += 4) set_word(a, 32'h1000_0000 | a);
        set_word(0, 32'h200a000a);
        for (int a = 32'h28; a <= 32'h34; a += 4) set_word(a, 32'h0);
        set_word(32'h40, 32'h0); set_word(32'h44, 32'h0);
        set_word(32'h4C, 32'h0); set_word(32'h50, 32'h0);
        set_word(32'hFC, 32'hdeadbeef);
    endtask

    task automatic test_reset();
        init_dir_mem();
        do_reset();
        n_checks++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h required 0", pc_o); end
        n_checks++; if (instr_o !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h required 0", instr_o); end
        n_checks++; if (pc4_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc4: got %h required 0", pc4_o); end
        n_checks++; if ({valid_o, halted_o, fault_o} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b required 000", {valid_o, halted_o, fault_o}); end
    endtask

    task automatic test_fetch();
        tick();
        n_checks++; if (instr_o !== 32'h200a000a) begin n_fail++; $display("FAIL fetch_instr: got %h required 200a000a", instr_o); end
        n_checks++; if (pc4_o !== 32'h4 || valid_o !== 1'b1) begin n_fail++; $display("FAIL fetch_pc4: got %h/%b required 4/1", pc4_o, valid_o); end
        n_checks++; if (pc_o !== 32'h4) begin n_fail++; $display("FAIL fetch_pc1: got %h required 4", pc_o); end
        tick();
        n_checks++; if (pc_o !== 32'h8 || instr_o !== 32'h10000004) begin n_fail++; $display("FAIL fetch_pc2: got %h/%h required 8/10000004", pc_o, instr_o); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (pc_o !== 32'h8 || instr_o !== 32'h10000004 || pc4_o !== 32'h8 || valid_o !== 1'b1) begin
                n_fail++; $display("FAIL stall_hold: got pc %h instr %h pc4 %h v %b required 8/10000004/8/1", pc_o, instr_o, pc4_o, valid_o);
            end
        end
        stall = 1'b0;
        tick();
        n_checks++; if (instr_o !== 32'h10000008 || pc4_o !== 32'hC || pc_o !== 32'hC) begin n_fail++; $display("FAIL stall_resume: got %h/%h/%h required 10000008/c/c", instr_o, pc4_o, pc_o); end
    endtask

    task automatic test_redirect();
        redirect = 1'b1; rpc = 32'h14; stall = 1'b1;
        tick();
        n_checks++; if (pc_o !== 32'h14 || valid_o !== 1'b0 || fault_o !== 1'b0) begin n_fail++; $display("FAIL redirect_stall: got %h/%b/%b required 14/0/0", pc_o, valid_o, fault_o); end
        redirect = 1'b0; stall = 1'b0;
        tick();
        n_checks++; if (instr_o !== 32'h10000014 || pc_o !== 32'h18 || valid_o !== 1'b1) begin n_fail++; $display("FAIL redirect_fetch: got %h/%h/%b required 10000014/18/1", instr_o, pc_o, valid_o); end
    endtask

    task automatic test_halt();
        redirect = 1'b1; rpc = 32'h28;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < HN; i++) begin
            tick();
            n_checks++;
            if (halted_o !== (i == HN - 1) || pc_o !== ((i == HN - 1) ? 32'h34 : 32'h2C + 32'(4 * i))) begin
                n_fail++; $display("FAIL halt_run%0d: got halted %b pc %h", i, halted_o, pc_o);
            end
        end
        n_checks++; if (instr_o !== 32'h0 || valid_o !== 1'b1 || pc4_o !== 32'h38) begin n_fail++; $display("FAIL halt_last_nop: got %h/%b/%h required 0/1/38", instr_o, valid_o, pc4_o); end
        repeat (2) begin
            tick();
            n_checks++; if (valid_o !== 1'b0 || pc_o !== 32'h34 || halted_o !== 1'b1) begin n_fail++; $display("FAIL halt_frozen: got v %b pc %h h %b required 0/34/1", valid_o, pc_o, halted_o); end
        end
        redirect = 1'b1; rpc = 32'h40;
        tick();
        redirect = 1'b0;
        n_checks++; if (halted_o !== 1'b0 || pc_o !== 32'h40) begin n_fail++; $display("FAIL halt_unhalt: got %b/%h required 0/40", halted_o, pc_o); end
        repeat (5) tick();
        n_checks++; if (halted_o !== 1'b0 || pc_o !== 32'h54) begin n_fail++; $display("FAIL nop_count_clear: got %b/%h required 0/54", halted_o, pc_o); end
    endtask

    task automatic test_fault();
        do_reset();
        redirect = 1'b1; rpc = 32'hFC;
        tick();
        redirect = 1'b0;
        tick();
        n_checks++; if (instr_o !== 32'hdeadbeef || fault_o !== 1'b0 || pc_o !== 32'h100) begin n_fail++; $display("FAIL edge_fetch: got %h/%b/%h required deadbeef/0/100", instr_o, fault_o, pc_o); end
        tick();
        n_checks++; if (instr_o !== 32'h0 || valid_o !== 1'b1 || fault_o !== 1'b1 || pc4_o !== 32'h104) begin n_fail++; $display("FAIL oor_fetch: got %h/%b/%b/%h required 0/1/1/104", instr_o, valid_o, fault_o, pc4_o); end
        do_reset();
        redirect = 1'b1; rpc = 32'h1F;
        tick();
        redirect = 1'b0;
        n_checks++; if (pc_o !== 32'h1C || fault_o !== 1'b1) begin n_fail++; $display("FAIL misaligned: got %h/%b required 1c/1", pc_o, fault_o); end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick(); tick();
        stall = 1'b1;
        tick();
        #2 reset = 1'b1;
        #1;
        n_checks++; if (pc_o !== 32'h0 || valid_o !== 1'b0 || instr_o !== 32'h0 || pc4_o !== 32'h0) begin n_fail++; $display("FAIL areset_stall: got %h/%b/%h/%h required 0/0/0/0", pc_o, valid_o, instr_o, pc4_o); end
        stall = 1'b0;
        @(posedge clk); #1; reset = 1'b0; model_reset();
        redirect = 1'b1; rpc = 32'h2B;
        tick();
        redirect = 1'b0;
        repeat (HN) tick();
        n_checks++; if (halted_o !== 1'b1 || fault_o !== 1'b1) begin n_fail++; $display("FAIL pre_areset_halt: got %b/%b required 1/1", halted_o, fault_o); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (halted_o !== 1'b0 || fault_o !== 1'b0 || pc_o !== 32'h0 || valid_o !== 1'b0) begin n_fail++; $display("FAIL areset_halt: got %b/%b/%h/%b required 0/0/0/0", halted_o, fault_o, pc_o, valid_o); end
        @(posedge clk); #1; reset = 1'b0; model_reset();
    endtask

    task automatic test_random();
        for (int a = 0; a < MEMB; a += 4)
            set_word(a, ($urandom_range(0, 1) == 0) ? 32'h0 : ($urandom | 32'h1));
        do_reset();
        for (int c = 0; c < 600; c++) begin
            stall    = ($urandom_range(0, 3) == 0);
            redirect = ($urandom_range(0, 11) == 0);
            rpc      = 32'($urandom_range(0, 287));
            tick();
            n_checks++;
            if (pc_o !== m_pc || valid_o !== m_valid || halted_o !== m_halt || fault_o !== m_fault ||
                instr_o !== m_instr || (m_valid && pc4_o !== m_pc4)) begin
                n_fail++;
                $display("FAIL random_c%0d: got pc %h v %b h %b f %b i %h p4 %h required pc %h v %b h %b f %b i %h p4 %h",
                         c, pc_o, valid_o, halted_o, fault_o, instr_o, pc4_o, m_pc, m_valid, m_halt, m_fault, m_instr, m_pc4);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_redirect();
        test_halt();
        test_fault();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
